// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter. It converts one input bit per clock.
// A conversion starts on a start request, or in AUTO mode whenever the input differs from the last converted value.
module bin_to_bcd_seq #(
   parameter int BIT_WIDTH = 8,
   parameter int DIGITS    = 3,
   parameter bit AUTO      = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIT_WIDTH-1:0]  in,
   input  logic                  start,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  busy,
   output logic                  done
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIT_WIDTH + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] CONV = 1'b1;

   // True when DIGITS decimal digits can hold the largest BIT_WIDTH-bit value.
   function automatic bit digits_fit(input int bw, input int nd);
      longint unsigned max_in;
      longint unsigned pow10;
      if (bw < 1 || bw > 63 || nd < 1) return 1'b0;
      max_in = (64'd1 << bw) - 64'd1;
      pow10  = 64'd1;
      for (int i = 0; i < nd; i++) begin
         pow10 = pow10 * 64'd10;
         if (pow10 > max_in) return 1'b1;
      end
      return 1'b0;
   endfunction

   generate
      if (!digits_fit(BIT_WIDTH, DIGITS)) begin : g_bad_digits
         $error("bin_to_bcd_seq: DIGITS=%0d too small for BIT_WIDTH=%0d", DIGITS, BIT_WIDTH);
      end
   endgenerate

   logic [0:0]           r_state;
   logic [BIT_WIDTH-1:0] r_shift;
   logic [BIT_WIDTH-1:0] r_last;
   logic [BCD_W-1:0]     r_scratch;
   logic [CNT_W-1:0]     r_cnt;
   logic [BCD_W-1:0]     r_out;
   logic                 r_busy;
   logic                 r_done;

   logic [BCD_W-1:0]     w_adj;
   logic [BCD_W-1:0]     w_next_scratch;
   logic                 w_trigger;
   logic                 w_last_shift;

   always_comb begin
      // NOTE: defaulting every always_comb output first keeps partial assignments from inferring latches.
      w_adj = r_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
         end
      end
   end

   assign w_next_scratch = {w_adj[BCD_W-2:0], r_shift[BIT_WIDTH-1]};
   assign w_trigger      = start | (AUTO & (in != r_last));
   assign w_last_shift   = (r_cnt == CNT_W'(BIT_WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_last    <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_out     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_trigger) begin
                  r_state   <= CONV;
                  r_busy    <= 1'b1;
                  r_shift   <= in;
                  r_last    <= in;
                  r_scratch <= '0;
                  r_cnt     <= '0;
               end
            end
            CONV: begin
               r_scratch <= w_next_scratch;
               r_shift   <= r_shift << 1;
               r_cnt     <= r_cnt + CNT_W'(1);
               if (w_last_shift) begin
                  r_out   <= w_next_scratch;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_bcd = r_out;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule
